mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arb_pkg.sv | 12 +
 rtl/mult_core.sv | 56 +++++
 rtl/mult_arbiter.sv | 100 ++++++++++
 tb/tb_mult_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the two-requester shift-add multiplier arbiter.
package mult_arb_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMult = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/mult_core.sv
// Shift-add multiplier datapath: one multiplier bit per step, product accumulated 2*WIDTH wide.
// Optional MULT_ARB_EARLY_EXIT_EN: flag the last step as soon as the remaining multiplier is zero.
module mult_core
  import mult_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] product_next
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t LastCnt = cnt_t'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  cnt_t               cnt_q;

  // Value the accumulator takes after the step in progress; the final one is the product.
  always_comb begin
    product_next = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef MULT_ARB_EARLY_EXIT_EN
    last = (cnt_q == LastCnt) || ((mplier_q >> 1) == '0);
`else
    last = (cnt_q == LastCnt);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      acc_q    <= '0;
      mplier_q <= b;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= product_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + cnt_t'(1);
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of a shared shift-add multiplier with a held response register.
// Build option MULT_ARB_EARLY_EXIT_EN (in mult_core) shortens MULT for small multipliers.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_data,
  output logic               busy
);

  state_e             state_q, state_d;
  logic               gnt_id, accept, core_step, core_last;
  logic               last_gnt_q, op_id_q, resp_id_q;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [2*WIDTH-1:0] core_product, resp_data_q;

  // On a tie the requester not granted last wins; otherwise the lone valid one.
  always_comb begin
    gnt_id    = (req0_valid && req1_valid) ? ~last_gnt_q : ~req0_valid;
    accept    = (state_q == StIdle) && (req0_valid || req1_valid);
    core_step = (state_q == StMult);
    sel_a     = gnt_id ? req1_a : req0_a;
    sel_b     = gnt_id ? req1_b : req0_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StMult;
      StMult:  if (core_last) state_d = StDone;
      StDone:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ready is masked during reset so nothing looks accepted while rst is low.
  always_comb begin
    req0_ready = rst && (state_q == StIdle) && req0_valid && !gnt_id;
    req1_ready = rst && (state_q == StIdle) && req1_valid && gnt_id;
    resp_valid = (state_q == StDone);
    busy       = (state_q != StIdle);
    resp_id    = resp_id_q;
    resp_data  = resp_data_q;
  end

  // Pointer resets to "last granted 1" so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_q  <= 1'b1;
      op_id_q     <= 1'b0;
      resp_id_q   <= 1'b0;
      resp_data_q <= '0;
    end else begin
      if (accept) begin
        last_gnt_q <= gnt_id;
        op_id_q    <= gnt_id;
      end
      if (core_step && core_last) begin
        resp_data_q <= core_product;
        resp_id_q   <= op_id_q;
      end
    end
  end

  mult_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .load         (accept),
    .step         (core_step),
    .a            (sel_a),
    .b            (sel_b),
    .last         (core_last),
    .product_next (core_product)
  );

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: transaction-level reference model plus directed pins.
module tb_mult_arbiter;

  localparam int unsigned W = 4;

`ifdef MULT_ARB_EARLY_EXIT_EN
  localparam int LatB5 = 3;
  localparam int LatB0 = 1;
`else
  localparam int LatB5 = 4;
  localparam int LatB0 = 4;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           resp_valid, resp_ready, resp_id, busy;
  logic [2*W-1:0] resp_data;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult_arbiter #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Number of MULT cycles an operation with multiplier b occupies.
  function automatic int steps_for(input logic [W-1:0] b);
`ifdef MULT_ARB_EARLY_EXIT_EN
    int n = 0;
    for (int i = 0; i < int'(W); i++) if (b[i]) n = i + 1;
    return (n == 0) ? 1 : n;
`else
    return int'(W);
`endif
  endfunction

  // Reference model: an operation is idle, computing (cycles left), or holding a response.
  bit             m_working = 0, m_done = 0, m_id = 0, m_prio = 0, m_opid = 0;
  int             m_left = 0;
  logic [2*W-1:0] m_data = '0, m_prod = '0;

  always @(negedge clk) begin
    bit idle, e_r0, e_r1;
    if (!rst) begin
      m_working = 0; m_done = 0; m_data = '0; m_id = 0; m_prio = 0;
    end
    idle = !m_working && !m_done;
    e_r0 = rst && idle && req0_valid && (!req1_valid || m_prio == 1'b0);
    e_r1 = rst && idle && req1_valid && (!req0_valid || m_prio == 1'b1);
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    chk("busy", busy, !idle);
    chk("resp_valid", resp_valid, m_done);
    chk("resp_data", resp_data, m_data);
    chk("resp_id", resp_id, m_id);
    if (rst) begin
      if (m_done) begin
        if (resp_ready) m_done = 0;
      end else if (m_working) begin
        m_left--;
        if (m_left == 0) begin
          m_working = 0; m_done = 1; m_data = m_prod; m_id = m_opid;
        end
      end else if (e_r0 || e_r1) begin
        m_opid = e_r1;
        m_prio = !e_r1;
        m_prod = e_r1 ? (2*W)'(int'(req1_a) * int'(req1_b))
                      : (2*W)'(int'(req0_a) * int'(req0_b));
        m_left = e_r1 ? steps_for(req1_b) : steps_for(req0_b);
        m_working = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v0, input int a0, input int b0,
                         input logic v1, input int a1, input int b1);
    req0_valid = v0; req0_a = W'(a0); req0_b = W'(b0);
    req1_valid = v1; req1_a = W'(a1); req1_b = W'(b1);
    #1;
  endtask

  // Ticks until resp_valid is seen; k is the number of edges waited.
  task automatic wait_valid(output int k);
    k = 0;
    while (!resp_valid && k < 40) begin
      tick();
      k++;
    end
    if (k >= 40) chk("resp_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int k;
    int got;
    int to;
    int seen;
    int exp_g[4] = '{0, 1, 0, 1};
    int g_seq[4];

    rst = 1'b0;
    resp_ready = 1'b0;
    set_req(1, 3, 3, 1, 4, 4);
    tick();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_data", resp_data, 0);
    set_req(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;

    // Single requester 3*5.
    set_req(1, 3, 5, 0, 0, 0);
    chk("r031_ready0", req0_ready, 1);
    tick();
    set_req(0, 0, 0, 0, 0, 0);
    wait_valid(k);
    chk("r031_latency", k, LatB5);
    chk("r031_data", resp_data, 15);
    chk("r031_id", resp_id, 0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("r031_valid_drop", resp_valid, 0);
    chk("r031_data_hold", resp_data, 15);

    // Tie after reset: 15*15 on req0 then 2*7 on req1.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_req(1, 15, 15, 1, 2, 7);
    chk("r032_tie_ready0", req0_ready, 1);
    chk("r032_tie_ready1", req1_ready, 0);
    tick();
    wait_valid(k);
    chk("r032_data0", resp_data, 225);
    chk("r032_id0", resp_id, 0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("r032_next_ready1", req1_ready, 1);
    chk("r032_next_ready0", req0_ready, 0);
    tick();
    wait_valid(k);
    chk("r032_data1", resp_data, 14);
    chk("r032_id1", resp_id, 1);

    // Continuous contention: grants must alternate.
    resp_ready = 1'b1;
    got = 0;
    to  = 0;
    while (got < 4 && to < 100) begin
      if (req0_ready || req1_ready) begin
        g_seq[got] = int'(req1_ready);
        got++;
      end
      tick();
      to++;
    end
    chk("r033_count", got, 4);
    for (int i = 0; i < 4; i++) chk("r033_grant", g_seq[i], exp_g[i]);
    set_req(0, 0, 0, 0, 0, 0);
    resp_ready = 1'b0;
    wait_valid(k);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Back-pressure in DONE.
    set_req(1, 6, 7, 1, 5, 5);
    tick();
    wait_valid(k);
    for (int i = 0; i < 3; i++) begin
      chk("r034_valid", resp_valid, 1);
      chk("r034_data", resp_data, 42);
      chk("r034_id", resp_id, 0);
      chk("r034_ready0", req0_ready, 0);
      chk("r034_ready1", req1_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    chk("r034_idle", busy, 0);
    chk("r034_valid_drop", resp_valid, 0);
    chk("r034_data_hold", resp_data, 42);
    resp_ready = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);

    // Reset during the second MULT cycle.
    set_req(1, 7, 3, 0, 0, 0);
    tick();
    set_req(1, 1, 1, 1, 1, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("r035_busy", busy, 0);
    chk("r035_valid", resp_valid, 0);
    chk("r035_data", resp_data, 0);
    chk("r035_ready0", req0_ready, 0);
    chk("r035_ready1", req1_ready, 0);
    set_req(0, 0, 0, 0, 0, 0);
    tick();
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid) seen++;
      tick();
    end
    chk("r035_no_resp", seen, 0);
    set_req(1, 2, 2, 1, 3, 3);
    chk("r035_tie_ready0", req0_ready, 1);
    chk("r035_tie_ready1", req1_ready, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0);
    wait_valid(k);
    chk("r035_after_data", resp_data, 4);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Zero multiplier latency.
    set_req(1, 9, 0, 0, 0, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0);
    wait_valid(k);
    chk("r036_latency", k, LatB0);
    chk("r036_data", resp_data, 0);
    resp_ready = 1'b1;
    tick();

    // Randomized traffic, with occasional one-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      req0_valid = ($urandom % 4) != 0;
      req1_valid = ($urandom % 4) != 0;
      req0_a     = W'($urandom);
      req0_b     = W'($urandom);
      req1_a     = W'($urandom);
      req1_b     = W'($urandom);
      resp_ready = ($urandom % 3) != 0;
      rst        = ($urandom % 400) != 0;
      tick();
    end
    rst = 1'b1;
    set_req(0, 0, 0, 0, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
